pipe_hazard_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage MIPS datapath.
- Drives enable, flush and bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the EX-stage forwarding selects.
- Resolves load-use stalls, taken-branch flushes and multi-cycle data-memory waits with a small FSM.
- Keeps saturating stall and flush performance counters.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/fwd_unit.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forwarding select codes and FSM state encoding.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage forwarding select for one source operand.
// EX/MEM result wins over MEM/WB; $zero is never forwarded.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic       mem_regwrite,
  input  logic [4:0] mem_wreg,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_wreg,
  output logic [1:0] sel
);

  // Youngest producer first, register file as fallback
  always_comb begin
    sel = FWD_RF;
    if (mem_regwrite && mem_wreg != REG_ZERO
        && mem_wreg == src)
      sel = FWD_MEM;
    else if (wb_regwrite && wb_wreg != REG_ZERO
             && wb_wreg == src)
      sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline controller: stalls, flushes,
// memory-wait freeze, forwarding selects and perf counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memread,
  input  logic             branch_taken,
  input  logic             mem_memread,
  input  logic             mem_memwrite,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_wreg,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_wreg,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] TMO = WC_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       memop, load_use;
  logic       freeze, release_en, br_flush;

  fwd_unit u_fwd_a (
    .src          (ex_rs),
    .mem_regwrite (mem_regwrite),
    .mem_wreg     (mem_wreg),
    .wb_regwrite  (wb_regwrite),
    .wb_wreg      (wb_wreg),
    .sel          (fwd_a_raw)
  );

  fwd_unit u_fwd_b (
    .src          (ex_rt),
    .mem_regwrite (mem_regwrite),
    .mem_wreg     (mem_wreg),
    .wb_regwrite  (wb_regwrite),
    .wb_wreg      (wb_wreg),
    .sel          (fwd_b_raw)
  );

  assign memop    = mem_memread | mem_memwrite;
  assign load_use = ex_memread & (ex_rt != REG_ZERO)
                  & ((ex_rt == id_rs)
                  | (id_uses_rt & (ex_rt == id_rt)));

  // FSM next state plus all pipeline control outputs
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    mem_err_d    = mem_err_q;
    freeze       = 1'b0;
    release_en   = 1'b0;
    br_flush     = 1'b0;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    fwd_a        = fwd_a_raw;
    fwd_b        = fwd_b_raw;

    unique case (state_q)
      RUN: begin
        if (memop && !dmem_ready) begin
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end else begin
          release_en = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          release_en = 1'b1;
          state_d    = RUN;
        end else if (wait_cnt_q == TMO) begin
          mem_err_d  = 1'b1;
          release_en = 1'b1;
          state_d    = RUN;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    if (freeze) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (release_en) begin
      // Branch beats load-use: the ID instruction dies anyway
      priority case (1'b1)
        branch_taken: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          br_flush   = 1'b1;
        end
        load_use: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
        default: ;
      endcase
    end

    if (reset) begin
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
      fwd_a        = FWD_RF;
      fwd_b        = FWD_RF;
      br_flush     = 1'b0;
    end
  end

  // Saturating performance counter updates
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_en && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);
    if (br_flush && flush_q != '1)
      flush_d = flush_q + CNT_W'(1);
  end

  // State, wait timer, error flag and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with directed vectors.
// A 4-bit-counter instance shares stimulus for saturation.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt;
  logic       id_uses_rt, ex_memread, branch_taken;
  logic       mem_memread, mem_memwrite, mem_regwrite;
  logic [4:0] mem_wreg, wb_wreg;
  logic       wb_regwrite, dmem_ready;

  logic        pc_en, ifid_en, idex_en, exmem_en;
  logic        ifid_flush, idex_flush, memwb_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic        mem_err;
  logic [15:0] stall_cycles, flush_count;

  logic        pc_en4, ifid_en4, idex_en4, exmem_en4;
  logic        ifid_flush4, idex_flush4, memwb_bubble4;
  logic [1:0]  fwd_a4, fwd_b4;
  logic        mem_err4;
  logic [3:0]  stall4, flush4;

  pipe_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(15)) u_dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread),
    .branch_taken(branch_taken),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
    .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg),
    .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipe_hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(15)) u_dut4 (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread),
    .branch_taken(branch_taken),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg),
    .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg),
    .dmem_ready(dmem_ready),
    .pc_en(pc_en4), .ifid_en(ifid_en4), .idex_en(idex_en4),
    .exmem_en(exmem_en4), .ifid_flush(ifid_flush4),
    .idex_flush(idex_flush4), .memwb_bubble(memwb_bubble4),
    .fwd_a(fwd_a4), .fwd_b(fwd_b4), .mem_err(mem_err4),
    .stall_cycles(stall4), .flush_count(flush4)
  );

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, bubble}
  localparam logic [6:0] C_RST = 7'b1111_111;
  localparam logic [6:0] C_NRM = 7'b1111_000;
  localparam logic [6:0] C_LU  = 7'b0011_010;
  localparam logic [6:0] C_BR  = 7'b1111_110;
  localparam logic [6:0] C_FRZ = 7'b0000_001;

  typedef struct {
    string       n;
    logic [6:0]  c;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        e;
    logic [15:0] s;
    logic [15:0] f;
    logic [3:0]  s4;
    logic [3:0]  f4;
  } exp_t;

  exp_t q[$];
  exp_t ex;
  int checks = 0;
  int errors = 0;

  task automatic cmp(string n, string what,
                     logic [15:0] act, logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s: got %h want %h", n, what, act, req);
    end
  endtask

  // Monitor: pops one expectation per cycle, samples mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      ex = q.pop_front();
      cmp(ex.n, "ctrl", 16'({pc_en, ifid_en, idex_en, exmem_en,
          ifid_flush, idex_flush, memwb_bubble}), 16'(ex.c));
      cmp(ex.n, "fwd_a", 16'(fwd_a), 16'(ex.fa));
      cmp(ex.n, "fwd_b", 16'(fwd_b), 16'(ex.fb));
      cmp(ex.n, "mem_err", 16'(mem_err), 16'(ex.e));
      cmp(ex.n, "stall", stall_cycles, ex.s);
      cmp(ex.n, "flush", flush_count, ex.f);
      cmp(ex.n, "w4_outs", 16'({pc_en4, ifid_en4, idex_en4,
          exmem_en4, ifid_flush4, idex_flush4, memwb_bubble4,
          fwd_a4, fwd_b4, mem_err4}),
          16'({ex.c, ex.fa, ex.fb, ex.e}));
      cmp(ex.n, "stall4", 16'(stall4), 16'(ex.s4));
      cmp(ex.n, "flush4", 16'(flush4), 16'(ex.f4));
    end
  end

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_memread = 0;
    branch_taken = 0;
    mem_memread = 0; mem_memwrite = 0;
    mem_regwrite = 0; mem_wreg = 0;
    wb_regwrite = 0; wb_wreg = 0;
    dmem_ready = 1;
  endtask

  task automatic chk(string n, logic [6:0] c,
                     logic [1:0] fa, logic [1:0] fb, logic e,
                     int s, int f);
    exp_t x;
    x.n  = n;
    x.c  = c;
    x.fa = fa;
    x.fb = fb;
    x.e  = e;
    x.s  = 16'(s);
    x.f  = 16'(f);
    x.s4 = (s > 15) ? 4'd15 : 4'(s);
    x.f4 = (f > 15) ? 4'd15 : 4'(f);
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    @(posedge clk);
    #1;
    chk("reset", C_RST, 2'b00, 2'b00, 0, 0, 0);
    reset = 0;
    chk("post_reset", C_NRM, 2'b00, 2'b00, 0, 0, 0);

    // Forwarding priority and $zero handling
    ex_rs = 5; ex_rt = 7;
    mem_regwrite = 1; mem_wreg = 5;
    wb_regwrite = 1; wb_wreg = 5;
    chk("fwd_mem", C_NRM, 2'b10, 2'b00, 0, 0, 0);
    mem_wreg = 0;
    chk("fwd_wb", C_NRM, 2'b01, 2'b00, 0, 0, 0);
    wb_wreg = 0;
    chk("fwd_none", C_NRM, 2'b00, 2'b00, 0, 0, 0);
    ex_rt = 3; wb_wreg = 3; mem_wreg = 4;
    chk("fwd_b_wb", C_NRM, 2'b00, 2'b01, 0, 0, 0);
    mem_regwrite = 0; mem_wreg = 5; wb_regwrite = 0;
    chk("fwd_nowr", C_NRM, 2'b00, 2'b00, 0, 0, 0);

    // Load-use stalls
    idle();
    ex_memread = 1; ex_rt = 9; id_rs = 9;
    chk("lu_rs", C_LU, 2'b00, 2'b00, 0, 0, 0);
    idle();
    chk("lu_after", C_NRM, 2'b00, 2'b00, 0, 1, 0);
    ex_memread = 1; ex_rt = 0; id_rs = 0;
    chk("lu_zero", C_NRM, 2'b00, 2'b00, 0, 1, 0);
    idle();
    ex_memread = 1; ex_rt = 4; id_rt = 4; id_rs = 2;
    id_uses_rt = 1;
    chk("lu_rt", C_LU, 2'b00, 2'b00, 0, 1, 0);
    id_uses_rt = 0;
    chk("lu_rt_unused", C_NRM, 2'b00, 2'b00, 0, 2, 0);

    // Branch wins over load-use
    idle();
    branch_taken = 1; ex_memread = 1; ex_rt = 9; id_rs = 9;
    chk("br_lu", C_BR, 2'b00, 2'b00, 0, 2, 0);
    idle();
    chk("br_after", C_NRM, 2'b00, 2'b00, 0, 2, 1);

    // Three-cycle memory wait, zero-bubble release
    mem_memread = 1; dmem_ready = 0;
    chk("mw_1", C_FRZ, 2'b00, 2'b00, 0, 2, 1);
    chk("mw_2", C_FRZ, 2'b00, 2'b00, 0, 3, 1);
    chk("mw_3", C_FRZ, 2'b00, 2'b00, 0, 4, 1);
    dmem_ready = 1;
    chk("mw_rel", C_NRM, 2'b00, 2'b00, 0, 5, 1);
    idle();
    chk("mw_after", C_NRM, 2'b00, 2'b00, 0, 5, 1);

    // Branch deferred by a wait, taken on release
    mem_memwrite = 1; dmem_ready = 0; branch_taken = 1;
    chk("mwb_frz", C_FRZ, 2'b00, 2'b00, 0, 5, 1);
    dmem_ready = 1;
    chk("mwb_rel", C_BR, 2'b00, 2'b00, 0, 6, 1);
    idle();
    chk("mwb_after", C_NRM, 2'b00, 2'b00, 0, 6, 2);

    // Timeout: 15 frozen cycles, released on the 16th
    mem_memread = 1; dmem_ready = 0;
    for (int i = 0; i < 15; i++)
      chk("tmo_frz", C_FRZ, 2'b00, 2'b00, 0, 6 + i, 2);
    chk("tmo_rel", C_NRM, 2'b00, 2'b00, 0, 21, 2);
    idle();
    chk("tmo_err", C_NRM, 2'b00, 2'b00, 1, 21, 2);
    mem_memread = 1;
    chk("err_sticky", C_NRM, 2'b00, 2'b00, 1, 21, 2);

    // Reset clears error and counters
    idle();
    reset = 1;
    chk("reset2", C_RST, 2'b00, 2'b00, 1, 21, 2);
    reset = 0;
    chk("reset2_after", C_NRM, 2'b00, 2'b00, 0, 0, 0);

    // Reset aborts a wait without raising mem_err
    mem_memread = 1; dmem_ready = 0;
    chk("abort_1", C_FRZ, 2'b00, 2'b00, 0, 0, 0);
    chk("abort_2", C_FRZ, 2'b00, 2'b00, 0, 1, 0);
    reset = 1;
    chk("abort_rst", C_RST, 2'b00, 2'b00, 0, 2, 0);
    reset = 0;
    idle();
    chk("abort_after", C_NRM, 2'b00, 2'b00, 0, 0, 0);
    mem_memread = 1; dmem_ready = 0;
    chk("reenter", C_FRZ, 2'b00, 2'b00, 0, 0, 0);
    idle();
    chk("reenter_rel", C_NRM, 2'b00, 2'b00, 0, 1, 0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
